// File: rtl/sub_bytes_seq_pkg.sv
// rtl/sub_bytes_seq_pkg.sv - shared AES constants: S-box tables, widths, FSM encoding
// Inverse table is only present when SUB_BYTES_INV_EN is defined.
package sub_bytes_seq_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Entry 0 sits in the most significant byte so SBOX_FWD[x] reads naturally.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
`endif

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES byte substitution
// Inverse select input exists only with SUB_BYTES_INV_EN.
module aes_sbox
  import sub_bytes_seq_pkg::*;
(
  input  logic [7:0] i_byte,
`ifdef SUB_BYTES_INV_EN
  input  logic       i_inv,
`endif
  output logic [7:0] o_byte
);

`ifdef SUB_BYTES_INV_EN
  assign o_byte = i_inv ? SBOX_INV[i_byte] : SBOX_FWD[i_byte];
`else
  assign o_byte = SBOX_FWD[i_byte];
`endif

endmodule

// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - iterative AES SubBytes, one column per cycle via four shared S-boxes
// Optional inverse substitution under SUB_BYTES_INV_EN.
module sub_bytes_seq
  import sub_bytes_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
`ifdef SUB_BYTES_INV_EN
  input  logic               inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STATE_W-1:0] r_work;
  logic [1:0]         r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [COL_W-1:0]   w_col;
  logic [COL_W-1:0]   w_sub;
  logic               w_accept;
`ifdef SUB_BYTES_INV_EN
  logic               r_inv;
`endif

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)      w_state_nxt = ST_BUSY;
      ST_BUSY: if (r_cnt == 2'd3) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)     w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_col = '0;
    case (r_cnt)
      2'd0: w_col = r_work[127:96];
      2'd1: w_col = r_work[95:64];
      2'd2: w_col = r_work[63:32];
      2'd3: w_col = r_work[31:0];
      default: w_col = '0;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_col[COL_W-1-8*g -: 8]),
`ifdef SUB_BYTES_INV_EN
      .i_inv  (r_inv),
`endif
      .o_byte (w_sub[COL_W-1-8*g -: 8])
    );
  end

  // Handshake flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work      <= '0;
      r_cnt       <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_work <= in_state;
        r_cnt  <= 2'd0;
`ifdef SUB_BYTES_INV_EN
        r_inv  <= inv;
`endif
      end else if (r_state == ST_BUSY) begin
        case (r_cnt)
          2'd0: r_work[127:96] <= w_sub;
          2'd1: r_work[95:64]  <= w_sub;
          2'd2: r_work[63:32]  <= w_sub;
          2'd3: r_work[31:0]   <= w_sub;
          default: ;
        endcase
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_state = r_work;

endmodule
